capture_controller: RTL

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

---
 rtl/scope_pkg.sv | 27 ++
 rtl/sample_counter.sv | 28 ++
 rtl/capture_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared encodings for the scope capture controller: FSM states, front-panel
// modes and the width of the auto-trigger timeout counter.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_SWAP    = 3'd4
    } capture_state_t;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_AUTO   = 2'd2,
        MODE_SINGLE = 2'd3
    } capture_mode_t;

    localparam int AUTO_COUNT_WIDTH = 20;

    // SINGLE only starts a capture on an explicit arm pulse; NORMAL/AUTO free-run.
    function automatic logic starts_capture(input capture_mode_t mode, input logic arm);
        return (mode != MODE_STOP) && ((mode != MODE_SINGLE) || arm);
    endfunction

endpackage

// File: rtl/sample_counter.sv
// Accepted-sample counter with clear, enable and an exact terminal compare.
// Holds at the terminal value rather than wrapping.
module sample_counter
    import scope_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count;

    assign at_terminal = (count == terminal);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !at_terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/capture_controller.sv
// Sequences the circular sample buffer: pre-trigger fill, trigger wait (with
// optional auto timeout), post-trigger fill and a display-safe frame lock.
//
//   state   | meaning
//   IDLE    | collection disabled, waiting for a run mode (or arm in SINGLE)
//   PREFILL | gathering the pre-trigger history, triggers ignored
//   ARMED   | history full, waiting for a qualified or forced trigger
//   POST    | gathering post-trigger samples
//   SWAP    | last sample pending; lock it once the display is not busy
module capture_controller
    import scope_pkg::*;
#(
    parameter int LOG_SAMPLES  = 10,
    parameter int PRE_TRIGGER  = 512,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sample_ready,
    input  logic       trigger_event,
    input  logic [1:0] mode,
    input  logic       arm,
    input  logic       display_busy,
    output logic       buf_disable_collection,
    output logic       buf_is_trigger,
    output logic       buf_lock_trigger,
    output logic [7:0] frame_count,
    output logic       auto_triggered,
    output logic [2:0] state_out
);

    localparam int DEPTH        = 1 << LOG_SAMPLES;
    localparam int POST_SAMPLES = DEPTH - PRE_TRIGGER - 1;
    // The final post-trigger sample is the one locked in SWAP, so POST itself
    // covers one sample fewer; with a single post sample POST is skipped.
    localparam bit SKIP_POST = (POST_SAMPLES == 1);

    localparam logic [LOG_SAMPLES-1:0] PREFILL_LAST = LOG_SAMPLES'(PRE_TRIGGER - 1);
    localparam logic [LOG_SAMPLES-1:0] POST_LAST    =
        SKIP_POST ? '0 : LOG_SAMPLES'(POST_SAMPLES - 2);
    localparam logic [AUTO_COUNT_WIDTH-1:0] AUTO_LIMIT = AUTO_COUNT_WIDTH'(AUTO_TIMEOUT);

    capture_state_t                state;
    capture_state_t                state_next;
    capture_mode_t                 mode_sel;
    logic                          accepted;
    logic                          count_enable;
    logic                          count_clear;
    logic                          at_terminal;
    logic [LOG_SAMPLES-1:0]        terminal;
    logic [AUTO_COUNT_WIDTH-1:0]   auto_count;
    logic                          auto_expired;
    logic                          auto_pending;
    logic                          fire_trigger;
    logic                          fire_auto;
    logic                          fire_lock;

    assign mode_sel               = capture_mode_t'(mode);
    assign buf_disable_collection = (state == ST_IDLE);
    assign accepted               = sample_ready && !buf_disable_collection;
    assign auto_expired           = (mode_sel == MODE_AUTO) && (auto_count == AUTO_LIMIT);

    assign terminal     = (state == ST_POST) ? POST_LAST : PREFILL_LAST;
    assign count_enable = accepted && ((state == ST_PREFILL) || (state == ST_POST));
    assign count_clear  = (state_next != state);

    sample_counter #(
        .WIDTH (LOG_SAMPLES)
    ) u_sample_counter (
        .clock       (clock),
        .reset       (reset),
        .clear       (count_clear),
        .enable      (count_enable),
        .terminal    (terminal),
        .at_terminal (at_terminal)
    );

    always_comb begin
        state_next   = state;
        fire_trigger = 1'b0;
        fire_auto    = 1'b0;
        fire_lock    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (starts_capture(mode_sel, arm)) begin
                    state_next = ST_PREFILL;
                end
            end
            ST_PREFILL: begin
                if (accepted && at_terminal) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (accepted && (trigger_event || auto_expired)) begin
                    fire_trigger = 1'b1;
                    fire_auto    = !trigger_event;
                    state_next   = SKIP_POST ? ST_SWAP : ST_POST;
                end
            end
            ST_POST: begin
                if (accepted && at_terminal) begin
                    state_next = ST_SWAP;
                end
            end
            ST_SWAP: begin
                if (accepted && !display_busy) begin
                    fire_lock  = 1'b1;
                    state_next = (mode_sel == MODE_SINGLE) ? ST_IDLE : ST_PREFILL;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Reset and STOP abandon the frame: no strobes go to the buffer.
        if (reset || (mode_sel == MODE_STOP)) begin
            state_next   = ST_IDLE;
            fire_trigger = 1'b0;
            fire_auto    = 1'b0;
            fire_lock    = 1'b0;
        end
    end

    assign buf_is_trigger   = fire_trigger;
    assign buf_lock_trigger = fire_lock;
    assign state_out        = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            auto_count     <= '0;
            auto_pending   <= 1'b0;
            auto_triggered <= 1'b0;
            frame_count    <= '0;
        end else begin
            state <= state_next;

            // Counts every accepted ARMED sample so a switch into AUTO sees
            // the time already spent waiting; saturates at the limit.
            if (state != ST_ARMED) begin
                auto_count <= '0;
            end else if (accepted && (auto_count != AUTO_LIMIT)) begin
                auto_count <= auto_count + 1'b1;
            end

            if (fire_trigger) begin
                auto_pending <= fire_auto;
            end

            if (fire_lock) begin
                frame_count    <= frame_count + 8'd1;
                auto_triggered <= auto_pending;
            end
        end
    end

endmodule
